// File: rtl/wisc_pkg.sv
// Shared ISA and fetch-pipe definitions for the WISC core.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
//
// Contents: opcode constants (OP_HLT = 4'hF), the NOP/bubble word, the PC
// width and the fetch FSM state type.
package wisc_pkg;

    localparam int PC_W = 16;

    // Opcode field is instr[15:12].
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_CAL = 4'hD;
    localparam logic [3:0] OP_RET = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Bubble inserted into IF/ID; decodes as a harmless ADD to r0.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } fetch_state_t;

    function automatic logic is_hlt(input logic [15:0] instr);
        return instr[15:12] == OP_HLT;
    endfunction

endpackage

// File: rtl/fetch_unit_ifid.sv
// IF/ID pipeline register with load / hold / bubble controls.
// Latency: 1 cycle from control to outputs.
// Backpressure: neither load nor bubble means hold (stall); bubble beats load.
//
// Ports: clk, rst (sync, active-high); i_load, i_bubble controls;
// i_instr, i_pc_next data in; o_instr, o_pc, o_valid registered out.
module IFID_reg
    import wisc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_bubble,
    input  logic [15:0]     i_instr,
    input  logic [PC_W-1:0] i_pc_next,
    output logic [15:0]     o_instr,
    output logic [PC_W-1:0] o_pc,
    output logic            o_valid
);

    logic [15:0]     r_instr;
    logic [PC_W-1:0] r_pc;
    logic            r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (i_bubble) begin
            // PC field is left alone: it is meaningless once valid drops.
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc    <= i_pc_next;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_valid = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC mux, FETCH/HALT FSM, IF/ID.
// Latency: imem_rd/imem_addr combinational from PC; captured word in IF/ID 1 cycle later.
// Backpressure: hazard freezes PC and IF/ID and drops imem_rd; imem_ready=0 inserts bubbles.
//
// Optional feature macro: FETCH_HALT_EN (HLT opcode 4'hF halts fetch until PC_update).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   hazard              decode-stage stall request
//   PC_update           resume pulse out of HALT
//   redirect, redirect_target   taken branch/call/ret and its new PC
//   imem_rd, imem_addr  instruction memory request
//   imem_rdata, imem_ready      instruction memory response
//   instr_out, PC_out, instr_valid  IF/ID register
//   halted              FSM is in HALT
module fetch_unit
    import wisc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            hazard,
    input  logic            PC_update,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_target,
    output logic            imem_rd,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            imem_ready,
    output logic [15:0]     instr_out,
    output logic [PC_W-1:0] PC_out,
    output logic            instr_valid,
    output logic            halted
);

    logic [PC_W-1:0] r_pc;
    fetch_state_t    r_state;

    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_next;
    fetch_state_t    w_state_next;
    logic            w_fetching;
    logic            w_capture;
    logic            w_bubble;
    logic            w_hlt_seen;

    assign w_pc_inc   = r_pc + 1'b1;   // natural 16-bit wrap 0xFFFF -> 0x0000
    assign w_fetching = (r_state == ST_FETCH) && !hazard;

    assign imem_rd   = !rst && w_fetching;
    assign imem_addr = r_pc;

    // A redirect squashes whatever the memory returns in the same cycle.
    assign w_capture = w_fetching && imem_ready && !redirect;

    // HALT keeps flushing IF/ID even while decode asserts hazard.
    assign w_bubble  = redirect
                     || (r_state == ST_HALT)
                     || (w_fetching && !imem_ready);

`ifdef FETCH_HALT_EN
    assign w_hlt_seen = w_capture && is_hlt(imem_rdata);
    assign halted     = (r_state == ST_HALT);
`else
    assign w_hlt_seen = 1'b0;
    assign halted     = 1'b0;
`endif

    always_comb begin
        w_pc_next    = r_pc;
        w_state_next = r_state;
        if (redirect) begin
            w_pc_next    = redirect_target;
            w_state_next = ST_FETCH;
        end else if (w_capture) begin
            // HLT still advances the PC so resume continues past it.
            w_pc_next = w_pc_inc;
            if (w_hlt_seen) begin
                w_state_next = ST_HALT;
            end
        end else if ((r_state == ST_HALT) && PC_update) begin
            // Resume wins over hazard; PC already points past the HLT.
            w_state_next = ST_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_state <= ST_FETCH;
        end else begin
            r_pc    <= w_pc_next;
            r_state <= w_state_next;
        end
    end

    IFID_reg u_ifid (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_capture),
        .i_bubble  (w_bubble),
        .i_instr   (imem_rdata),
        .i_pc_next (w_pc_inc),
        .o_instr   (instr_out),
        .o_pc      (PC_out),
        .o_valid   (instr_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic.
// Latency: expectations are queued per cycle and consumed by a monitor on negedge.
// Backpressure: n/a.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hazard = 1'b0;
    logic        PC_update = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_target = 16'h0000;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic        imem_ready = 1'b0;
    logic [15:0] instr_out;
    logic [15:0] PC_out;
    logic        instr_valid;
    logic        halted;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .hazard          (hazard),
        .PC_update       (PC_update),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_rd         (imem_rd),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .imem_ready      (imem_ready),
        .instr_out       (instr_out),
        .PC_out          (PC_out),
        .instr_valid     (instr_valid),
        .halted          (halted)
    );

    typedef struct {
        bit          chk_regs;
        bit          chk_pcout;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] instr;
        logic [15:0] pcout;
        logic        valid;
        logic        halted;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model: architectural view of the fetch stage.
    int          m_pc = 0;
    bit          m_halt = 1'b0;
    logic [15:0] m_instr = 16'h0000;
    logic [15:0] m_pcout = 16'h0000;
    bit          m_valid = 1'b0;
    bit          m_known = 1'b0;
    bit          m_pcout_known = 1'b0;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus: drive, queue the expectation, advance the model.
    task automatic cyc(input bit r, input bit h, input bit u, input bit rd,
                       input logic [15:0] tgt, input bit rdy, input logic [15:0] data);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; hazard = h; PC_update = u; redirect = rd;
        redirect_target = tgt; imem_ready = rdy; imem_rdata = data;

        e.chk_regs  = m_known;
        e.chk_pcout = m_known && m_pcout_known;
        e.rd        = !r && !m_halt && !h;
        e.addr      = 16'(m_pc);
        e.instr     = m_instr;
        e.pcout     = m_pcout;
        e.valid     = m_valid;
        e.halted    = m_halt;
        sb.push_back(e);

        if (r) begin
            m_pc = 0; m_halt = 1'b0; m_instr = 16'h0000; m_pcout = 16'h0000;
            m_valid = 1'b0; m_pcout_known = 1'b1; m_known = 1'b1;
        end else if (rd) begin
            m_pc = int'(tgt); m_halt = 1'b0; m_instr = 16'h0000;
            m_valid = 1'b0; m_pcout_known = 1'b0;
        end else if (m_halt) begin
            m_instr = 16'h0000; m_valid = 1'b0; m_pcout_known = 1'b0;
            if (u) m_halt = 1'b0;
        end else if (h) begin
            // stall: nothing changes
        end else if (rdy) begin
            m_pc = (m_pc + 1) % 65536;
            m_instr = data; m_pcout = 16'(m_pc); m_valid = 1'b1; m_pcout_known = 1'b1;
`ifdef FETCH_HALT_EN
            if (data[15:12] == 4'hF) m_halt = 1'b1;
`endif
        end else begin
            m_instr = 16'h0000; m_valid = 1'b0; m_pcout_known = 1'b0;
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    endtask

    task automatic jump(input logic [15:0] tgt);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, tgt, 1'b0, 16'h0000);
    endtask

    task automatic fetch(input logic [15:0] data);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, data);
    endtask

    // Monitor: one queued expectation per cycle, compared mid-cycle.
    initial begin : monitor
        exp_t me;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                me = sb.pop_front();
                check16("imem_rd", 16'(imem_rd), 16'(me.rd));
                if (me.chk_regs) begin
                    check16("imem_addr",   imem_addr,          me.addr);
                    check16("instr_out",   instr_out,          me.instr);
                    check16("instr_valid", 16'(instr_valid),   16'(me.valid));
                    check16("halted",      16'(halted),        16'(me.halted));
                end
                if (me.chk_pcout) check16("PC_out", PC_out, me.pcout);
            end
        end
    end

    initial begin : stim
        bit          r_r, r_h, r_u, r_d, r_rdy;
        logic [15:0] r_tgt, r_data;

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 16'hF000);

        // First fetch right after reset, then two back-to-back words.
        fetch(16'h1234);
        #3;
        check16("first_fetch_rd",   16'(imem_rd), 16'h0001);
        check16("first_fetch_addr", imem_addr,    16'h0000);
        check16("reset_valid",      16'(instr_valid), 16'h0000);
        fetch(16'h5678);
        idle();
        #3;
        check16("two_word_instr", instr_out, 16'h5678);
        check16("two_word_pcout", PC_out,    16'h0002);
        check16("two_word_valid", 16'(instr_valid), 16'h0001);

        // Three-cycle stall at PC 5 with memory responding (must be ignored).
        jump(16'h0004);
        fetch(16'h4BCD);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'($urandom));
            #3;
            check16("stall_rd",    16'(imem_rd), 16'h0000);
            check16("stall_addr",  imem_addr,    16'h0005);
            check16("stall_instr", instr_out,    16'h4BCD);
            check16("stall_pcout", PC_out,       16'h0005);
        end
        idle();
        #3;
        check16("resume_rd",   16'(imem_rd), 16'h0001);
        check16("resume_addr", imem_addr,    16'h0005);

        // Redirect beats a simultaneous hazard.
        jump(16'h0010);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'h0040, 1'b1, 16'h9999);
        idle();
        #3;
        check16("redir_addr",  imem_addr,         16'h0040);
        check16("redir_valid", 16'(instr_valid), 16'h0000);

        // PC wrap.
        jump(16'hFFFF);
        fetch(16'h2222);
        idle();
        #3;
        check16("wrap_pcout", PC_out,    16'h0000);
        check16("wrap_addr",  imem_addr, 16'h0000);

`ifdef FETCH_HALT_EN
        jump(16'h0007);
        fetch(16'hF000);
        idle();
        #3;
        check16("hlt_halted", 16'(halted),  16'h0001);
        check16("hlt_addr",   imem_addr,    16'h0008);
        check16("hlt_rd",     16'(imem_rd), 16'h0000);
        check16("hlt_instr",  instr_out,    16'hF000);
        for (int i = 0; i < 4; i++) idle();
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h3333);
        idle();
        #3;
        check16("resume_addr8",   imem_addr,    16'h0008);
        check16("resume_rd8",     16'(imem_rd), 16'h0001);
        check16("resume_halted0", 16'(halted),  16'h0000);
        // Hazard together with PC_update still resumes.
        fetch(16'hF123);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h4444);
        idle();
        #3;
        check16("haz_resume_halted", 16'(halted), 16'h0000);
        check16("haz_resume_addr",   imem_addr,   16'h0009);
        // Reset out of HALT while memory is not ready.
        fetch(16'hF000);
        idle();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        idle();
        #3;
        check16("rst_halt_halted", 16'(halted),      16'h0000);
        check16("rst_halt_valid",  16'(instr_valid), 16'h0000);
        check16("rst_halt_addr",   imem_addr,        16'h0000);
`else
        jump(16'h0007);
        fetch(16'hF000);
        idle();
        #3;
        check16("hlt_ignored_halted", 16'(halted),  16'h0000);
        check16("hlt_ignored_addr",   imem_addr,    16'h0008);
        check16("hlt_ignored_rd",     16'(imem_rd), 16'h0001);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        idle();
        #3;
        check16("rst_wait_addr",  imem_addr,        16'h0000);
        check16("rst_wait_valid", 16'(instr_valid), 16'h0000);
`endif

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            r_r   = ($urandom_range(99) == 0);
            r_h   = ($urandom_range(3) == 0);
            r_u   = ($urandom_range(4) == 0);
            r_d   = ($urandom_range(9) == 0);
            r_tgt = ($urandom_range(3) == 0) ? 16'(16'hFFFC + 16'($urandom_range(3)))
                                             : 16'($urandom);
            r_rdy = ($urandom_range(9) < 7);
            r_data = 16'($urandom);
            if ($urandom_range(7) == 0) r_data[15:12] = 4'hF;
            cyc(r_r, r_h, r_u, r_d, r_tgt, r_rdy, r_data);
        end

        @(posedge clk);
        #1;
        rst = 1'b0; hazard = 1'b0; PC_update = 1'b0; redirect = 1'b0; imem_ready = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have exactly one clock, clk, and one reset, rst; rst SHALL be synchronous and active-high.
REQ-002 The block SHALL expose these ports:
- clk  in  1  global clock.
- rst  in  1  synchronous active-high reset.
- hazard  in  1  stall request from the decode-stage hazard detector.
- PC_update  in  1  resume pulse that releases a halted pipe.
- redirect  in  1  branch/call/ret taken.
- redirect_target  in  16  new PC on redirect.
- imem_rd  out  1  instruction memory read request.
- imem_addr  out  16  word address of the fetch.
- imem_rdata  in  16  fetched instruction word.
- imem_ready  in  1  imem_rdata is valid this cycle.
- instr_out  out  16  IF/ID instruction field.
- PC_out  out  16  IF/ID PC+1 of the fetched instruction.
- instr_valid  out  1  IF/ID slot holds a real instruction.
- halted  out  1  the fetch state machine is in HALT.

Function
REQ-003 The PC SHALL be a 16-bit word address that increments by 1 and wraps from 0xFFFF to 0x0000.
REQ-004 The FSM SHALL have two states, FETCH and HALT.
REQ-005 In FETCH with hazard=0, imem_rd SHALL be 1 and imem_addr SHALL equal the PC, combinationally.
REQ-006 In FETCH on imem_ready=1, hazard=0 and redirect=0, the IF/ID register SHALL load {imem_rdata, PC+1, valid=1} and PC SHALL advance to PC+1 at the next edge (1-cycle latency).
REQ-007 In FETCH on imem_ready=0, hazard=0 and redirect=0, the PC SHALL hold and the IF/ID register SHALL load a bubble (instr_out=0x0000, instr_valid=0); the request stays asserted.
REQ-008 hazard=1 SHALL hold the PC and the IF/ID register unchanged and drive imem_rd=0; any imem_ready in that cycle SHALL be ignored.
REQ-009 redirect=1 SHALL override hazard and imem_ready: PC SHALL load redirect_target, the IF/ID register SHALL load a bubble, and the state SHALL become FETCH, including from HALT.
REQ-010 In HALT, imem_rd SHALL be 0, halted SHALL be 1, the IF/ID register SHALL load bubbles and the PC SHALL hold.
REQ-011 In HALT, PC_update=1 SHALL return the FSM to FETCH at the next edge with the PC unchanged, so the PC points past the HLT.
REQ-012 PC_update SHALL be ignored in FETCH.
REQ-013 If hazard=1 and PC_update=1 arrive together in HALT, the FSM SHALL still resume.

Reset
REQ-014 On rst=1 at a clock edge, the following SHALL take effect regardless of every other input, including mid-stall, mid-wait and in HALT:
- PC=0x0000, state=FETCH.
- instr_out=0x0000, PC_out=0x0000, instr_valid=0, halted=0.
REQ-015 While rst=1, imem_rd SHALL be 0.
REQ-016 The first fetch SHALL issue in the first cycle after rst deasserts, at address 0x0000.

Configuration
REQ-017 With FETCH_HALT_EN defined, a captured word whose bits [15:12] equal the HLT opcode 4'hF SHALL do three things:
- be passed to IF/ID with valid=1;
- advance the PC;
- move the FSM to HALT at the same edge.
REQ-018 Without FETCH_HALT_EN, HLT SHALL be treated like any other instruction, HALT SHALL be unreachable and halted SHALL be tied to 0.

Structure
REQ-019 A shared package wisc_pkg SHALL hold:
- the opcode constants, including OP_HLT=4'hF;
- the NOP/bubble encoding 16'h0000;
- the PC width parameter (16);
- the FSM state enum.
REQ-020 The IF/ID storage SHALL be a sub-module IFID_reg with load, hold and bubble controls; the PC register, next-PC mux and FSM SHALL live in fetch_unit.

Verification
REQ-021 Reset, then imem_ready=1 each cycle with the words 0x1234 and 0x5678 -> after 2 cycles instr_out=0x5678, PC_out=0x0002, instr_valid=1.
REQ-022 PC=0x0005 with hazard=1 for 3 cycles -> imem_rd=0 and PC, instr_out and PC_out unchanged for all 3; the fetch at 0x0005 resumes in the cycle after hazard drops.
REQ-023 PC=0x0010 with redirect=1, redirect_target=0x0040 and hazard=1 in the same cycle -> next cycle imem_addr=0x0040 and instr_valid=0.
REQ-024 With FETCH_HALT_EN, fetch 0xF000 at PC=0x0007 -> halted=1, PC=0x0008, imem_rd=0; a PC_update pulse 5 cycles later gives imem_addr=0x0008 in the following cycle.
REQ-025 PC=0xFFFF with imem_ready=1 -> PC_out=0x0000 and the next imem_addr is 0x0000.
REQ-026 rst asserted while imem_ready=0 in HALT -> next cycle PC=0, state=FETCH, halted=0, instr_valid=0.
